// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//
// Packs per-type instruction fields into 32-bit instruction words and streams
// them into instruction memory at consecutive word addresses. A load begins
// with a start pulse and ends when the word carrying the stop bit retires. It
// is aborted with err if a non-stop word retires at the last memory address.
//
// Word layout (all types): [31]=stop, [30:29]=type, [4:0]=opcode
//   R: [9:5]=rs1 [14:10]=rd [19:15]=rs2 [28:20]=0
//   J: [28:5]=simm24
//   I: [9:5]=rs1 [14:10]=rd [28:15]=imm14
//   S: [9:5]=rs1 [14:10]=rd [19:15]=rs2 [24:20]=sa [28:25]=0
//
// Ports:
//   clk, rst               clock (rising edge), async active-high reset
//   start                  begin a program load (ignored while loading)
//   in_valid / in_ready    field-bundle handshake
//   instr_type             00 R, 01 J, 10 I, 11 S ("type" is a reserved word)
//   opcode, rs1, rd, rs2,
//   imm14, simm24, sa      instruction fields; unused ones are ignored
//   stop                   marks the last instruction of the program
//   mem_we / mem_ready     memory write handshake; held word is in mem_wdata
//   mem_addr, mem_wdata    write address and encoded instruction
//   count                  words retired in the current load
//   busy, done, err        loading / finished by stop word / overflow abort

module instr_encoder_loader #(
  parameter int unsigned       ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        instr_type,
  input  logic [4:0]        opcode,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs2,
  input  logic [13:0]       imm14,
  input  logic [23:0]       simm24,
  input  logic [4:0]        sa,
  input  logic              stop,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [1:0] TyR = 2'b00;
  localparam logic [1:0] TyJ = 2'b01;
  localparam logic [1:0] TyI = 2'b10;
  localparam logic [1:0] TyS = 2'b11;

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e              state_q, state_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [31:0] enc_word;
  logic        stop_pending;
  logic        accept;
  logic        retire;
  logic        at_last_addr;

  // Field packing; unused fields of each type never reach the word.
  always_comb begin
    enc_word = '0;
    unique case (instr_type)
      TyR: enc_word[19:5]  = {rs2, rd, rs1};
      TyJ: enc_word[28:5]  = simm24;
      TyI: enc_word[28:5]  = {imm14, rd, rs1};
      TyS: enc_word[24:5]  = {sa, rs2, rd, rs1};
      default: enc_word = '0;
    endcase
    enc_word[4:0]   = opcode;
    enc_word[30:29] = instr_type;
    enc_word[31]    = stop;
  end

  // The held word's stop bit doubles as the stop-pending flag: once a stop
  // word is accepted no further word is taken until it retires.
  assign stop_pending = mem_we_q && mem_wdata_q[31];
  assign busy         = (state_q == StLoad);
  assign in_ready     = busy && !stop_pending && (!mem_we_q || mem_ready);
  assign accept       = in_valid && in_ready;
  assign retire       = mem_we_q && mem_ready;
  assign at_last_addr = &mem_addr_q;

  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    count_d     = count_q;
    done_d      = done_q;
    err_d       = err_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d    = StLoad;
          mem_we_d   = 1'b0;
          mem_addr_d = BASE_ADDR;
          count_d    = '0;
          done_d     = 1'b0;
          err_d      = 1'b0;
        end
      end
      StLoad: begin
        if (retire) begin
          count_d  = count_q + 1'b1;
          mem_we_d = 1'b0;
          if (mem_wdata_q[31]) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else if (at_last_addr) begin
            // No wrap-around: the load aborts with the address held.
            state_d = StDone;
            err_d   = 1'b1;
          end else begin
            mem_addr_d = mem_addr_q + 1'b1;
          end
        end
        // A word accepted on the overflowing edge is dropped with the load.
        if (accept && !(retire && !mem_wdata_q[31] && at_last_addr)) begin
          mem_we_d    = 1'b1;
          mem_wdata_d = enc_word;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      mem_wdata_q <= '0;
      count_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      count_q     <= count_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign count     = count_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Testbench for instr_encoder_loader: an 8-bit-address instance for the main
// checks and a 2-bit-address instance for the overflow abort.

module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [1:0]  instr_type;
  logic [4:0]  opcode, rs1, rd, rs2, sa;
  logic [13:0] imm14;
  logic [23:0] simm24;
  logic        stop;
  logic        mem_ready;

  logic        in_ready, mem_we, busy, done, err;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [8:0]  count;

  logic        s_in_ready, s_mem_we, s_busy, s_done, s_err;
  logic [1:0]  s_mem_addr;
  logic [31:0] s_mem_wdata;
  logic [2:0]  s_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(8'd0)) u_dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .instr_type(instr_type), .opcode(opcode), .rs1(rs1), .rd(rd), .rs2(rs2),
    .imm14(imm14), .simm24(simm24), .sa(sa), .stop(stop), .mem_we(mem_we),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .count(count),
    .busy(busy), .done(done), .err(err)
  );

  instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(2'd0)) u_small (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
    .instr_type(instr_type), .opcode(opcode), .rs1(rs1), .rd(rd), .rs2(rs2),
    .imm14(imm14), .simm24(simm24), .sa(sa), .stop(stop), .mem_we(s_mem_we),
    .mem_ready(mem_ready), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .count(s_count), .busy(s_busy), .done(s_done), .err(s_err)
  );

  typedef struct packed {
    logic [1:0]  ty;
    logic [4:0]  op;
    logic [4:0]  r1;
    logic [4:0]  rdd;
    logic [4:0]  r2;
    logic [13:0] imm;
    logic [23:0] simm;
    logic [4:0]  shamt;
    logic        st;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input vec_t v);
    instr_type = v.ty; opcode = v.op; rs1 = v.r1; rd = v.rdd; rs2 = v.r2;
    imm14 = v.imm; simm24 = v.simm; sa = v.shamt; stop = v.st;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Reference encoding built from field positions with plain arithmetic.
  function automatic logic [31:0] model_enc(input logic [1:0] ty, input logic [4:0] op,
                                            input logic [4:0] a, input logic [4:0] d,
                                            input logic [4:0] b, input logic [13:0] im,
                                            input logic [23:0] sim, input logic [4:0] sh,
                                            input logic st);
    longint w;
    w = longint'(op) + longint'(ty) * 64'd536870912 + longint'(st) * 64'd2147483648;
    case (ty)
      2'd0: w += longint'(a) * 32 + longint'(d) * 1024 + longint'(b) * 32768;
      2'd1: w += longint'(sim) * 32;
      2'd2: w += longint'(a) * 32 + longint'(d) * 1024 + longint'(im) * 32768;
      default: w += longint'(a) * 32 + longint'(d) * 1024 + longint'(b) * 32768
                    + longint'(sh) * 1048576;
    endcase
    return w[31:0];
  endfunction

  initial begin
    logic [7:0]  t_addr;
    int          t_cnt;
    bit          t_busy;
    logic [31:0] q[$];
    logic [31:0] w;
    logic [7:0]  m_addr;
    int          m_cnt, k, n, cyc;
    bit          m_busy, m_stopp, exp_ir, retire, acc;

    //                ty     op     rs1    rd     rs2    imm14     simm24      sa     stop  expected
    vecs[0] = '{2'b00, 5'd3,  5'd1,  5'd2,  5'd4,  14'h0,    24'h0,      5'd0,  1'b0, 32'h00020823};
    vecs[1] = '{2'b00, 5'd7,  5'd3,  5'd9,  5'd17, 14'h3FFF, 24'hFFFFFF, 5'd31, 1'b0, 32'h0008A467};
    vecs[2] = '{2'b01, 5'd0,  5'd31, 5'd31, 5'd31, 14'h3FFF, 24'h123456, 5'd31, 1'b0, 32'h22468AC0};
    vecs[3] = '{2'b11, 5'd9,  5'd2,  5'd3,  5'd4,  14'h3FFF, 24'hFFFFFF, 5'd5,  1'b0, 32'h60520C49};
    vecs[4] = '{2'b10, 5'd31, 5'd31, 5'd0,  5'd31, 14'h1234, 24'hFFFFFF, 5'd31, 1'b1, 32'hC91A03FF};
    vecs[5] = '{2'b01, 5'd1,  5'd7,  5'd7,  5'd7,  14'h155,  24'hFFFFFE, 5'd7,  1'b0, 32'h3FFFFFC1};
    vecs[6] = '{2'b10, 5'd2,  5'd5,  5'd6,  5'd31, 14'h3FFF, 24'hABCDEF, 5'd31, 1'b0, 32'h5FFF98A2};
    vecs[7] = '{2'b11, 5'd4,  5'd1,  5'd1,  5'd2,  14'h3FFF, 24'hFFFFFF, 5'd31, 1'b1, 32'hE1F10424};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; mem_ready = 1'b0;
    set_fields(vecs[0]);

    // Reset values
    #12;
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_count", count, 0);
    chk("rst_flags", {busy, done, err, in_ready}, 0);
    rst = 1'b0;
    step();

    // J, I, S stream at full throughput
    pulse_start();
    mem_ready = 1'b1; in_valid = 1'b1;
    set_fields(vecs[5]);
    step();
    chk("strm_j_we", mem_we, 1);
    chk("strm_j_addr", mem_addr, 0);
    chk("strm_j_data", mem_wdata, 32'h3FFFFFC1);
    set_fields(vecs[6]);
    step();
    chk("strm_i_addr", mem_addr, 1);
    chk("strm_i_data", mem_wdata, 32'h5FFF98A2);
    chk("strm_i_count", count, 1);
    set_fields(vecs[7]);
    step();
    chk("strm_s_addr", mem_addr, 2);
    chk("strm_s_data", mem_wdata, 32'hE1F10424);
    chk("strm_s_count", count, 2);
    chk("strm_stop_inready", in_ready, 0);
    in_valid = 1'b0;
    step();
    chk("strm_done", {done, err, busy, mem_we, in_ready}, 5'b10000);
    chk("strm_count", count, 3);
    chk("strm_addr_held", mem_addr, 2);

    // Backpressure: held word stays stable, next accept on the retire edge
    pulse_start();
    set_fields(vecs[0]);
    in_valid = 1'b1; mem_ready = 1'b0;
    step();
    set_fields(vecs[1]);
    for (int i = 0; i < 3; i++) begin
      chk("bp_we", mem_we, 1);
      chk("bp_addr", mem_addr, 0);
      chk("bp_data", mem_wdata, 32'h00020823);
      chk("bp_inready", in_ready, 0);
      step();
    end
    mem_ready = 1'b1;
    #1;
    chk("bp_release_inready", in_ready, 1);
    step();
    in_valid = 1'b0; mem_ready = 1'b0;
    chk("bp_next_addr", mem_addr, 1);
    chk("bp_next_count", count, 1);
    chk("bp_next_data", mem_wdata, 32'h0008A467);
    chk("bp_next_we", mem_we, 1);

    // Table: one word per vector, held for a cycle then retired
    do_reset();
    t_busy = 0; t_addr = 0; t_cnt = 0;
    foreach (vecs[i]) begin
      if (!t_busy) begin
        pulse_start();
        t_busy = 1; t_addr = 0; t_cnt = 0;
      end
      set_fields(vecs[i]);
      in_valid = 1'b1; mem_ready = 1'b0;
      step();
      in_valid = 1'b0;
      chk($sformatf("tbl%0d_we", i), mem_we, 1);
      chk($sformatf("tbl%0d_data", i), mem_wdata, vecs[i].exp);
      chk($sformatf("tbl%0d_addr", i), mem_addr, t_addr);
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      t_cnt++;
      if (vecs[i].st) t_busy = 0;
      else t_addr++;
      chk($sformatf("tbl%0d_count", i), count, t_cnt);
      chk($sformatf("tbl%0d_addr_after", i), mem_addr, t_addr);
      chk($sformatf("tbl%0d_busy_done", i), {busy, done}, {t_busy, !t_busy});
    end

    // Random traffic against a queue-level model, three loads
    do_reset();
    for (int ld = 0; ld < 3; ld++) begin
      pulse_start();
      q.delete();
      m_addr = 0; m_cnt = 0; m_busy = 1; m_stopp = 0; k = 0;
      n = $urandom_range(5, 25);
      cyc = 0;
      while (m_busy && cyc < 2000) begin
        cyc++;
        in_valid   = ($urandom_range(0, 3) != 0);
        mem_ready  = ($urandom_range(0, 2) != 0);
        instr_type = 2'($urandom); opcode = 5'($urandom); rs1 = 5'($urandom);
        rd = 5'($urandom); rs2 = 5'($urandom); imm14 = 14'($urandom);
        simm24 = 24'($urandom); sa = 5'($urandom);
        stop = (k == n - 1);
        #1;
        exp_ir = m_busy && !m_stopp && (q.size() == 0 || mem_ready);
        chk("rnd_inready", in_ready, exp_ir);
        chk("rnd_we", mem_we, q.size() != 0);
        if (q.size() != 0) chk("rnd_data", mem_wdata, q[0]);
        chk("rnd_addr", mem_addr, m_addr);
        chk("rnd_count", count, m_cnt);
        retire = (q.size() != 0) && mem_ready;
        acc    = in_valid && exp_ir;
        if (retire) begin
          w = q.pop_front();
          m_cnt++;
          if (w[31]) begin
            m_busy = 0; m_stopp = 0;
          end else begin
            m_addr++;
          end
        end
        if (acc) begin
          q.push_back(model_enc(instr_type, opcode, rs1, rd, rs2, imm14, simm24, sa, stop));
          k++;
          if (stop) m_stopp = 1;
        end
        step();
      end
      in_valid = 1'b0; mem_ready = 1'b0;
      chk("rnd_timeout", m_busy, 0);
      chk("rnd_end_flags", {done, err, busy, mem_we}, 4'b1000);
      chk("rnd_end_count", count, n);
    end

    // Overflow on the 2-bit-address instance
    do_reset();
    pulse_start();
    set_fields(vecs[0]);
    in_valid = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      opcode = 5'(i + 10);
      step();
    end
    in_valid = 1'b0;
    chk("ovf_pre_addr", s_mem_addr, 3);
    step();
    mem_ready = 1'b0;
    chk("ovf_err_done", {s_err, s_done}, 2'b10);
    chk("ovf_addr", s_mem_addr, 3);
    chk("ovf_count", s_count, 4);
    chk("ovf_busy_we", {s_busy, s_mem_we}, 0);
    pulse_start();
    chk("ovf_restart_err", s_err, 0);
    chk("ovf_restart_addr", s_mem_addr, 0);
    chk("ovf_restart_busy", s_busy, 1);

    // Asynchronous reset mid-load with a word held
    do_reset();
    pulse_start();
    set_fields(vecs[3]);
    in_valid = 1'b1; mem_ready = 1'b0;
    step();
    in_valid = 1'b0;
    chk("arst_pre_we", mem_we, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_we", mem_we, 0);
    chk("arst_addr", mem_addr, 0);
    chk("arst_data", mem_wdata, 0);
    chk("arst_count", count, 0);
    chk("arst_flags", {busy, done, err, in_ready}, 0);
    #2;
    rst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
